// File: rtl/sysctrl_wb_regfile_pkg.sv
// Shared definitions for the system-control Wishbone register file:
// register offsets, ack sequencer states and byte-lane helpers.
package sysctrl_pkg;

  localparam logic [31:0] SYSCTRL_BASE_ADR    = 32'h2620_0000;

  localparam logic [7:0]  SYSCTRL_CLK_OFS     = 8'h00;
  localparam logic [7:0]  SYSCTRL_TRAP_OFS    = 8'h04;
  localparam logic [7:0]  SYSCTRL_IRQSRC_OFS  = 8'h08;
  localparam logic [7:0]  SYSCTRL_IRQSTAT_OFS = 8'h0C;
  localparam logic [7:0]  SYSCTRL_IRQEN_OFS   = 8'h10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } ack_state_e;

  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    logic [31:0] mask;
    mask = 32'h0;
    for (int b = 0; b < 4; b++) begin
      mask[8*b +: 8] = {8{sel[b]}};
    end
    return mask;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  sel);
    logic [31:0] mask;
    mask = sel_to_mask(sel);
    return (old_word & ~mask) | (new_word & mask);
  endfunction

endpackage

// File: rtl/sysctrl_wb_regfile_if.sv
// Wishbone bus bundle between the management master and the sysctrl slave.
interface sysctrl_wb_regfile_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/sysctrl_wb_regfile_ack_fsm.sv
// IDLE/WAIT/ACK sequencer: inserts ACK_WAIT wait states, emits the commit
// strobe on the edge entering ACK and a registered one-cycle ack.
module wb_ack_fsm
  import sysctrl_pkg::*;
#(
  parameter int ACK_WAIT = 0
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic req,
  input  logic active,
  output logic commit,
  output logic ack
);

  localparam logic [1:0] WAIT_INIT = (ACK_WAIT > 0) ? 2'(ACK_WAIT - 1) : 2'd0;

  ack_state_e state_r;
  ack_state_e state_nxt_s;
  logic [1:0] cnt_r;
  logic [1:0] cnt_nxt_s;
  logic       ack_r;

  // State, wait counter and ack flop
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= 2'd0;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ack_r   <= (state_nxt_s == ST_ACK);
    end
  end

  // Next state; a master that drops stb/cyc while waiting aborts the access
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    commit      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          if (ACK_WAIT == 0) begin
            state_nxt_s = ST_ACK;
            commit      = 1'b1;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = WAIT_INIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!active) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == 2'd0) begin
          state_nxt_s = ST_ACK;
          commit      = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 2'd1;
        end
      end
      ST_ACK:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  assign ack = ack_r;

endmodule

// File: rtl/sysctrl_wb_regfile.sv
// Housekeeping system-control registers on the management Wishbone bus:
// pad-mux enables, IRQ source selects and edge-latched W1C IRQ status.
module sysctrl_wb_regfile
  import sysctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = SYSCTRL_BASE_ADR,
  parameter int          N_CLK    = 2,
  parameter int          N_IRQ    = 2,
  parameter int          ACK_WAIT = 0
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  sysctrl_wb_regfile_if.slave  wb,
  input  logic [N_IRQ-1:0]     irq_in,
  output logic [N_CLK-1:0]     clk_out_dest,
  output logic                 trap_out_dest,
  output logic [N_IRQ-1:0]     irq_src_sel,
  output logic                 irq_o
);

  logic             hit_s, active_s, req_s, aligned_s;
  logic             commit_s, ack_s, wr_s, rd_s;
  logic [7:0]       ofs_s;
  logic [31:0]      rd_data_s, wr_word_s, clr_bits_s;
  logic [N_IRQ-1:0] rise_s, status_nxt_s;
  logic             unused_ok_s;

  logic [N_CLK-1:0] clk_out_dest_r;
  logic             trap_out_dest_r;
  logic [N_IRQ-1:0] irq_src_r, irq_status_r, irq_en_r, irq_q_r;
  logic [31:0]      dat_o_r;

  assign hit_s     = (wb.wb_adr_i[31:8] == BASE_ADR[31:8]);
  assign active_s  = wb.wb_stb_i & wb.wb_cyc_i;
  assign req_s     = active_s & hit_s;
  assign aligned_s = (wb.wb_adr_i[1:0] == 2'b00);
  assign ofs_s     = wb.wb_adr_i[7:0];
  assign wr_s      = commit_s & wb.wb_we_i & aligned_s;
  assign rd_s      = commit_s & ~wb.wb_we_i;

  wb_ack_fsm #(.ACK_WAIT(ACK_WAIT)) u_ack_fsm (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .req      (req_s),
    .active   (active_s),
    .commit   (commit_s),
    .ack      (ack_s)
  );

  // Read mux; misaligned and unmapped offsets read as zero
  always_comb begin
    rd_data_s = 32'h0;
    if (aligned_s) begin
      case (ofs_s)
        SYSCTRL_CLK_OFS:     rd_data_s = 32'(clk_out_dest_r);
        SYSCTRL_TRAP_OFS:    rd_data_s = 32'(trap_out_dest_r);
        SYSCTRL_IRQSRC_OFS:  rd_data_s = 32'(irq_src_r);
        SYSCTRL_IRQSTAT_OFS: rd_data_s = 32'(irq_status_r);
        SYSCTRL_IRQEN_OFS:   rd_data_s = 32'(irq_en_r);
        default:             rd_data_s = 32'h0;
      endcase
    end else begin
      rd_data_s = 32'h0;
    end
  end

  assign wr_word_s   = byte_merge(rd_data_s, wb.wb_dat_i, wb.wb_sel_i);
  assign clr_bits_s  = wb.wb_dat_i & sel_to_mask(wb.wb_sel_i);
  assign rise_s      = irq_in & ~irq_q_r;
  assign unused_ok_s = ^{wr_word_s, clr_bits_s};

  // Status update: a new rising edge outranks a simultaneous W1C clear
  always_comb begin
    if (wr_s && (ofs_s == SYSCTRL_IRQSTAT_OFS)) begin
      status_nxt_s = (irq_status_r & ~clr_bits_s[N_IRQ-1:0]) | rise_s;
    end else begin
      status_nxt_s = irq_status_r | rise_s;
    end
  end

  // Register file, edge detector and read-data capture
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      clk_out_dest_r  <= '0;
      trap_out_dest_r <= 1'b0;
      irq_src_r       <= '0;
      irq_status_r    <= '0;
      irq_en_r        <= '0;
      irq_q_r         <= '0;
      dat_o_r         <= 32'h0;
    end else begin
      irq_q_r      <= irq_in;
      irq_status_r <= status_nxt_s;
      if (rd_s) begin
        dat_o_r <= rd_data_s;
      end
      if (wr_s) begin
        case (ofs_s)
          SYSCTRL_CLK_OFS:    clk_out_dest_r  <= wr_word_s[N_CLK-1:0];
          SYSCTRL_TRAP_OFS:   trap_out_dest_r <= wr_word_s[0];
          SYSCTRL_IRQSRC_OFS: irq_src_r       <= wr_word_s[N_IRQ-1:0];
          SYSCTRL_IRQEN_OFS:  irq_en_r        <= wr_word_s[N_IRQ-1:0];
          default:            ;
        endcase
      end
    end
  end

  assign wb.wb_ack_o   = ack_s;
  assign wb.wb_dat_o   = dat_o_r;
  assign clk_out_dest  = clk_out_dest_r;
  assign trap_out_dest = trap_out_dest_r;
  assign irq_src_sel   = irq_src_r;
  assign irq_o         = |(irq_status_r & irq_en_r);

endmodule

// File: tb/tb_sysctrl_wb_regfile.sv
// Randomised scoreboard bench for sysctrl_wb_regfile with a byte-level
// register model; a negedge monitor checks every ack against a queue.
module tb_sysctrl_wb_regfile;

  localparam logic [31:0] BASE     = 32'h2620_0000;
  localparam int          N_CLK    = 2;
  localparam int          N_IRQ    = 2;
  localparam int          ACK_WAIT = 3;
  localparam int          LAT      = ACK_WAIT + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_IRQ-1:0] irq_in;
  logic [N_CLK-1:0] clk_out_dest;
  logic             trap_out_dest;
  logic [N_IRQ-1:0] irq_src_sel;
  logic             irq_o;

  sysctrl_wb_regfile_if bus ();

  sysctrl_wb_regfile #(
    .BASE_ADR (BASE),
    .N_CLK    (N_CLK),
    .N_IRQ    (N_IRQ),
    .ACK_WAIT (ACK_WAIT)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wb            (bus),
    .irq_in        (irq_in),
    .clk_out_dest  (clk_out_dest),
    .trap_out_dest (trap_out_dest),
    .irq_src_sel   (irq_src_sel),
    .irq_o         (irq_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] dat_o;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  // Reference model: index = word offset / 4 (CLK, TRAP, IRQSRC, IRQSTAT, IRQEN)
  logic [31:0]      m_reg [5];
  logic [N_IRQ-1:0] m_irq_prev;
  logic [31:0]      m_last_rd;
  bit               prev_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 32'h%08h expected 32'h%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] impl_mask(input int idx);
    logic [31:0] one;
    one = 32'd1;
    case (idx)
      0:       return (one << N_CLK) - one;
      1:       return one;
      default: return (one << N_IRQ) - one;
    endcase
  endfunction

  function automatic int reg_idx(input logic [31:0] adr);
    if (adr[1:0] != 2'b00) return -1;
    if (adr[7:0] > 8'h10) return -1;
    return int'(adr[7:2]);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] adr);
    int idx;
    idx = reg_idx(adr);
    return (idx < 0) ? 32'h0 : m_reg[idx];
  endfunction

  task automatic model_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    int idx;
    idx = reg_idx(adr);
    if (idx >= 0) begin
      for (int b = 0; b < 4; b++) begin
        if (sel[b]) begin
          if (idx == 3) m_reg[3][8*b +: 8] = m_reg[3][8*b +: 8] & ~dat[8*b +: 8];
          else          m_reg[idx][8*b +: 8] = dat[8*b +: 8];
        end
      end
      m_reg[idx] = m_reg[idx] & impl_mask(idx);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_reg[i] = 32'h0;
    m_irq_prev = '0;
    m_last_rd  = 32'h0;
  endtask

  // Monitor: every ack must be expected, single-cycle, with the right read data
  always @(negedge clk) begin
    exp_t e;
    if (bus.wb_ack_o === 1'b1) begin
      chk("ack_single_cycle", {31'h0, prev_ack}, 32'h0);
      chk("ack_expected", {31'h0, (sb_q.size() > 0)}, 32'h1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.name, bus.wb_dat_o, e.dat_o);
      end
    end
    prev_ack = (bus.wb_ack_o === 1'b1);
  end

  // One bus access; lat = edges from request sample to visible ack, 0 = none
  task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input int drop_n, input int irq_n,
                      input logic [N_IRQ-1:0] irq_v, output int lat);
    lat = 0;
    @(posedge clk); #1;
    bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = adr;  bus.wb_dat_i = dat;  bus.wb_sel_i = sel;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == irq_n) irq_in = irq_v;
      if (bus.wb_ack_o === 1'b1) begin
        lat = n;
        break;
      end
      if (n == drop_n) break;
    end
    bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                          input string name);
    int lat;
    model_write(adr, dat, sel);
    sb_q.push_back('{m_last_rd, name});
    xfer(1'b1, adr, dat, sel, 0, 0, '0, lat);
    chk({name, "_lat"}, lat, LAT);
  endtask

  task automatic wb_read(input logic [31:0] adr, input string name);
    int lat;
    m_last_rd = model_read(adr);
    sb_q.push_back('{m_last_rd, name});
    xfer(1'b0, adr, 32'h0, 4'hF, 0, 0, '0, lat);
    chk({name, "_lat"}, lat, LAT);
  endtask

  task automatic check_outputs(input string name);
    chk({name, "_irq_o"}, {31'h0, irq_o}, {31'h0, |(m_reg[3] & m_reg[4])});
    chk({name, "_clk_out"}, 32'(clk_out_dest), m_reg[0]);
    chk({name, "_trap_out"}, {31'h0, trap_out_dest}, m_reg[1]);
    chk({name, "_irq_src"}, 32'(irq_src_sel), m_reg[2]);
  endtask

  task automatic set_irq(input logic [N_IRQ-1:0] v, input string name);
    @(posedge clk); #1;
    irq_in = v;
    m_reg[3] = m_reg[3] | 32'(v & ~m_irq_prev);
    m_irq_prev = v;
    @(posedge clk); #1;
    check_outputs(name);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] adr;
    bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_sel_i = 4'h0; bus.wb_adr_i = 32'h0; bus.wb_dat_i = 32'h0;
    irq_in = '0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", {31'h0, bus.wb_ack_o}, 32'h0);
    chk("reset_dat_o", bus.wb_dat_o, 32'h0);
    check_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) wb_read(BASE + 32'(4 * i), "reset_read");

    wb_write(BASE + 32'h00, 32'hFFFF_FFFF, 4'hF, "wr_clk_ones");
    wb_write(BASE + 32'h04, 32'hFFFF_FFFF, 4'hF, "wr_trap_ones");
    wb_write(BASE + 32'h08, 32'hFFFF_FFFF, 4'hF, "wr_src_ones");
    wb_read(BASE + 32'h00, "rd_clk_ones");
    wb_read(BASE + 32'h04, "rd_trap_ones");
    wb_read(BASE + 32'h08, "rd_src_ones");
    check_outputs("all_ones");

    // Abort: stb/cyc dropped while waiting, no ack and no write
    xfer(1'b1, BASE, 32'h0, 4'hF, 2, 0, '0, lat);
    chk("abort_lat", lat, 0);
    repeat (8) @(posedge clk);
    wb_read(BASE, "rd_after_abort");
    check_outputs("after_abort");

    set_irq(2'b10, "irq1_rise");
    wb_read(BASE + 32'h0C, "rd_status_irq1");
    wb_write(BASE + 32'h10, 32'h2, 4'hF, "wr_en_irq1");
    check_outputs("irq1_enabled");
    wb_write(BASE + 32'h0C, 32'h2, 4'hF, "w1c_irq1");
    wb_read(BASE + 32'h0C, "rd_status_cleared");
    check_outputs("irq1_cleared");
    set_irq(2'b00, "irq1_fall");

    // W1C on status[0] landing on the same edge as a new rise: set wins
    set_irq(2'b01, "irq0_rise");
    set_irq(2'b00, "irq0_fall");
    model_write(BASE + 32'h0C, 32'h1, 4'hF);
    m_reg[3] = m_reg[3] | 32'h1;
    m_irq_prev = 2'b01;
    sb_q.push_back('{m_last_rd, "w1c_vs_rise"});
    xfer(1'b1, BASE + 32'h0C, 32'h1, 4'hF, 0, ACK_WAIT, 2'b01, lat);
    chk("w1c_vs_rise_lat", lat, LAT);
    wb_read(BASE + 32'h0C, "rd_set_wins");
    set_irq(2'b00, "irq0_fall2");

    xfer(1'b1, BASE + 32'h100, 32'hFFFF_FFFF, 4'hF, 0, 0, '0, lat);
    chk("miss_lat", lat, 0);
    wb_write(BASE + 32'h14, 32'hFFFF_FFFF, 4'hF, "wr_unmapped");
    wb_read(BASE + 32'h14, "rd_unmapped");
    wb_write(BASE + 32'h01, 32'h0, 4'hF, "wr_unaligned");
    wb_read(BASE + 32'h02, "rd_unaligned");
    wb_read(BASE + 32'h00, "rd_clk_kept");

    // Reset while the sequencer is waiting
    @(posedge clk); #1;
    bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_adr_i = BASE + 32'h04; bus.wb_dat_i = 32'hFFFF_FFFF; bus.wb_sel_i = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
    model_reset();
    repeat (8) @(posedge clk);
    #1;
    chk("rst_mid_dat_o", bus.wb_dat_o, 32'h0);
    check_outputs("rst_mid");
    wb_read(BASE + 32'h04, "rd_after_rst_mid");

    for (int i = 0; i < 60; i++) begin
      int r;
      r   = int'($urandom_range(0, 9));
      adr = BASE + 32'(4 * $urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) adr = adr + 32'($urandom_range(1, 3));
      if (r < 2) begin
        set_irq(N_IRQ'($urandom), "rnd_irq");
      end else if (r < 6) begin
        wb_write(adr, $urandom, 4'($urandom), "rnd_wr");
        check_outputs("rnd_wr");
      end else begin
        wb_read(adr, "rnd_rd");
        check_outputs("rnd_rd");
      end
    end

    repeat (5) @(posedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
